fp_align_prep: RTL and testbench

FP_ALIGN_PREP -- requirements
Module: fp_align_prep

---
 rtl/fp_align_prep_pkg.sv | 35 +++
 rtl/fp_align_prep_unpack.sv | 21 ++
 rtl/fp_align_prep.sv | 102 ++++++++++
 tb/tb_fp_align_prep.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_align_prep_pkg.sv
// Shared float field widths and record types for the FP add/sub alignment-prep stage.
package fp_align_prep_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int FP_W   = 1 + EXP_W + FRAC_W;

  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  eff_exp;
    logic [MANT_W-1:0] mant;
    logic              special;
  } fp_unp_t;

  typedef struct packed {
    logic              sign_big;
    logic              sign_small;
    logic [EXP_W-1:0]  exp_big;
    logic [MANT_W-1:0] mant_big;
    logic [MANT_W-1:0] mant_small;
    logic [EXP_W-1:0]  shift_num;
    logic              swapped;
    logic              eff_sub;
    logic              special;
  } align_t;

  // Magnitude ordering key: effective exponent above mantissa.
  function automatic logic [EXP_W+MANT_W-1:0] mag_key(input fp_unp_t u);
    return {u.eff_exp, u.mant};
  endfunction

endpackage

// File: rtl/fp_align_prep_unpack.sv
// Combinational unpack of one single-precision operand into sign/eff_exp/mant/special.
module fp_unpack
  import fp_align_prep_pkg::*;
(
  input  logic [FP_W-1:0] i_f,
  output fp_unp_t         o_u
);

  logic [EXP_W-1:0] w_exp;
  logic             w_hidden;

  assign w_exp    = i_f[FP_W-2 -: EXP_W];
  assign w_hidden = (w_exp != '0);

  // Denormals share the exponent of the smallest normal.
  assign o_u.sign    = i_f[FP_W-1];
  assign o_u.eff_exp = w_hidden ? w_exp : EXP_W'(1);
  assign o_u.mant    = {w_hidden, i_f[FRAC_W-1:0]};
  assign o_u.special = (w_exp == EXP_SPECIAL);

endmodule

// File: rtl/fp_align_prep.sv
// Two-stage operand unpack, magnitude compare and swap feeding a right-shift aligner.
module fp_align_prep
  import fp_align_prep_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP_W-1:0]   a_in,
  input  logic [FP_W-1:0]   b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_big,
  output logic              sign_small,
  output logic [EXP_W-1:0]  exp_big,
  output logic [MANT_W-1:0] mant_big,
  output logic [MANT_W-1:0] mant_small,
  output logic [EXP_W-1:0]  shift_num,
  output logic              swapped,
  output logic              eff_sub,
  output logic              special
);

  fp_unp_t w_a_p0, w_b_p0;
  fp_unp_t r_a_p1, r_b_p1;
  logic    r_vld_p1, r_vld_p2;
  align_t  w_res_p1, r_res_p2, w_out;
  fp_unp_t w_big_p1, w_small_p1;
  logic    w_b_big_p1;
  logic    w_s1_load, w_s2_load;

  fp_unpack u_unpack_a (.i_f(a_in), .o_u(w_a_p0));
  fp_unpack u_unpack_b (.i_f(b_in), .o_u(w_b_p0));

  assign w_s2_load = !r_vld_p2 || out_ready;
  assign w_s1_load = !r_vld_p1 || w_s2_load;
  assign in_ready  = w_s1_load;

  // ---- stage p0 -> p1: unpacked operands
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else if (w_s1_load) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_s1_load && in_valid) begin
      r_a_p1 <= w_a_p0;
      r_b_p1 <= w_b_p0;
    end
  end

  // Ties leave A as the big operand.
  assign w_b_big_p1 = mag_key(r_b_p1) > mag_key(r_a_p1);
  assign w_big_p1   = w_b_big_p1 ? r_b_p1 : r_a_p1;
  assign w_small_p1 = w_b_big_p1 ? r_a_p1 : r_b_p1;

  always_comb begin
    w_res_p1            = '0;
    w_res_p1.sign_big   = w_big_p1.sign;
    w_res_p1.sign_small = w_small_p1.sign;
    w_res_p1.exp_big    = w_big_p1.eff_exp;
    w_res_p1.mant_big   = w_big_p1.mant;
    w_res_p1.mant_small = w_small_p1.mant;
    w_res_p1.shift_num  = w_big_p1.eff_exp - w_small_p1.eff_exp;
    w_res_p1.swapped    = w_b_big_p1;
    w_res_p1.eff_sub    = w_big_p1.sign ^ w_small_p1.sign;
    w_res_p1.special    = r_a_p1.special | r_b_p1.special;
  end

  // ---- stage p1 -> p2: compare/swap result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2 <= 1'b0;
    end else if (w_s2_load) begin
      r_vld_p2 <= r_vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_s2_load && r_vld_p1) begin
      r_res_p2 <= w_res_p1;
    end
  end

  // Data registers carry no reset; the outputs read zero whenever nothing valid is presented.
  assign out_valid = r_vld_p2 && !rst;
  assign w_out     = out_valid ? r_res_p2 : '0;

  assign sign_big   = w_out.sign_big;
  assign sign_small = w_out.sign_small;
  assign exp_big    = w_out.exp_big;
  assign mant_big   = w_out.mant_big;
  assign mant_small = w_out.mant_small;
  assign shift_num  = w_out.shift_num;
  assign swapped    = w_out.swapped;
  assign eff_sub    = w_out.eff_sub;
  assign special    = w_out.special;

endmodule

// File: tb/tb_fp_align_prep.sv
// Directed and randomized bench for fp_align_prep with an in-order scoreboard.
module tb_fp_align_prep;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        sign_big, sign_small, swapped, eff_sub, special;
  logic [7:0]  exp_big, shift_num;
  logic [23:0] mant_big, mant_small;

  fp_align_prep dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .sign_big(sign_big), .sign_small(sign_small), .exp_big(exp_big),
    .mant_big(mant_big), .mant_small(mant_small), .shift_num(shift_num),
    .swapped(swapped), .eff_sub(eff_sub), .special(special)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [68:0] q[$];
  logic [68:0] o_vec;
  logic        o_vld, o_rdy, o_acc;

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: for IEEE encodings magnitude order equals unsigned order of bits [30:0].
  function automatic logic [68:0] model(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, ebig, esml;
    logic [23:0] ma, mb;
    logic        sw, sa, sb, sp;
    ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
    ma = (a[30:23] == 0) ? {1'b0, a[22:0]} : {1'b1, a[22:0]};
    mb = (b[30:23] == 0) ? {1'b0, b[22:0]} : {1'b1, b[22:0]};
    sw = (b[30:0] > a[30:0]);
    sp = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    sa = a[31];
    sb = b[31];
    ebig = sw ? eb : ea;
    esml = sw ? ea : eb;
    if (sw) return {sb, sa, 8'(ebig), mb, ma, 8'(ebig - esml), 1'b1, sa ^ sb, sp};
    else    return {sa, sb, 8'(ebig), ma, mb, 8'(ebig - esml), 1'b0, sa ^ sb, sp};
  endfunction

  function automatic logic [31:0] rand_fp();
    int sel;
    logic [7:0] e;
    sel = $urandom_range(0, 9);
    e = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : (sel == 2) ? 8'd127 : 8'($urandom_range(0, 255));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // One clock: sample/score at the falling edge, then pass the rising edge.
  task automatic tick();
    @(negedge clk);
    o_vec = {sign_big, sign_small, exp_big, mant_big, mant_small, shift_num, swapped, eff_sub, special};
    o_vld = out_valid;
    o_rdy = in_ready;
    o_acc = in_valid && in_ready && !rst;
    if (rst) begin
      chk("rst_vld", 69'(out_valid), 69'(0));
      chk("rst_data", o_vec, 69'(0));
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) chk("stale_out", 69'(1), 69'(0));
        else begin
          chk("data", o_vec, q[0]);
          if (out_ready) void'(q.pop_front());
        end
      end
      if (o_acc) q.push_back(model(a_in, b_in));
    end
    @(posedge clk);
    #1;
  endtask

  // Single pair with no stall: result must appear exactly two cycles after accept.
  task automatic run_pair(input logic [31:0] a, input logic [31:0] b);
    out_ready = 1'b1;
    a_in = a; b_in = b; in_valid = 1'b1;
    tick();
    chk("accept", 69'(o_acc), 69'(1));
    in_valid = 1'b0;
    tick();
    chk("lat_early", 69'(o_vld), 69'(0));
    tick();
    chk("lat_2", 69'(o_vld), 69'(1));
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rdy_after_rst", 69'(o_rdy), 69'(1));
    chk("vld_after_rst", 69'(o_vld), 69'(0));

    run_pair(32'h3F800000, 32'h3F000000);
    chk("d1_exp", 69'(o_vec[66:59]), 69'(127));
    chk("d1_mb", 69'(o_vec[58:35]), 69'(24'h800000));
    chk("d1_ms", 69'(o_vec[34:11]), 69'(24'h800000));
    chk("d1_sh", 69'(o_vec[10:3]), 69'(1));
    chk("d1_sw_es", 69'(o_vec[2:1]), 69'(2'b00));

    run_pair(32'h3F000000, 32'hBF800000);
    chk("d2_signs", 69'(o_vec[68:67]), 69'(2'b10));
    chk("d2_sw_es", 69'(o_vec[2:1]), 69'(2'b11));
    chk("d2_sh", 69'(o_vec[10:3]), 69'(1));

    run_pair(32'h00000001, 32'h00800000);
    chk("d3_sw", 69'(o_vec[2]), 69'(1));
    chk("d3_exp", 69'(o_vec[66:59]), 69'(1));
    chk("d3_ms", 69'(o_vec[34:11]), 69'(24'h000001));
    chk("d3_sh", 69'(o_vec[10:3]), 69'(0));

    run_pair(32'h4B800000, 32'h3F800000);
    chk("d4_sh24", 69'(o_vec[10:3]), 69'(24));

    run_pair(32'h7F800000, 32'h3F800000);
    chk("d5_special", 69'(o_vec[0]), 69'(1));

    run_pair(32'h40490FDB, 32'h40490FDB);
    chk("d6_sw", 69'(o_vec[2]), 69'(0));
    chk("d6_sh", 69'(o_vec[10:3]), 69'(0));

    // Backpressure: two accepts fill both stages, then input stalls.
    out_ready = 1'b0;
    in_valid = 1'b1;
    a_in = 32'h40000000; b_in = 32'h3F800000; tick();
    chk("bp_acc0", 69'(o_acc), 69'(1));
    a_in = 32'hC0400000; b_in = 32'h41000000; tick();
    chk("bp_acc1", 69'(o_acc), 69'(1));
    a_in = 32'h00000010; b_in = 32'h80000020;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_rdy_low", 69'(o_rdy), 69'(0));
    end
    out_ready = 1'b1;
    begin
      int lim = 0;
      do begin tick(); lim++; end while (!o_acc && lim < 10);
      chk("bp_acc2", 69'(o_acc), 69'(1));
    end
    a_in = 32'h7FC00001; b_in = 32'h3F800000; tick();
    chk("bp_acc3", 69'(o_acc), 69'(1));
    in_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    chk("bp_drained", 69'(q.size()), 69'(0));

    // Reset with two pairs in flight.
    out_ready = 1'b0;
    in_valid = 1'b1;
    a_in = 32'h3F800000; b_in = 32'h40000000; tick();
    a_in = 32'h40400000; b_in = 32'h40800000; tick();
    rst = 1'b1;
    a_in = 32'h41000000; b_in = 32'h41100000; tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("rst_flush_vld", 69'(o_vld), 69'(0));
    chk("rst_flush_data", o_vec, 69'(0));
    chk("rst_flush_rdy", 69'(o_rdy), 69'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_stale", 69'(o_vld), 69'(0));
    end

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      a_in = rand_fp();
      b_in = rand_fp();
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    chk("rand_drained", 69'(q.size()), 69'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
